iot_sequencer: RTL and testbench

Controller that executes PDP-8/E IOT instructions (opcode 6) on the peripheral I/O bus. On a start request from the CPU it latches the instruction and drives the 6-bit device select. It then issues the IOP1, IOP2 and IOP4 strobes in order, each followed by a programmable settle gap that a slow device can stretch. During each strobe it wire-ORs the device skip, AC-clear and input-data responses, and returns them to the CPU with a one-cycle done pulse. It sits between the CPU state machine and the peripheral skip/data multiplexer.

---
 rtl/iot_sequencer.sv | 161 ++++++++++++++++
 tb/tb_iot_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_sequencer.sv
// PDP-8/E IOT sequencer: latches an opcode-6 instruction, drives the device select,
// and issues IOP1/IOP2/IOP4 with stretchable settle gaps.
module iot_sequencer #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:11] instruction,
    input  logic        io_skip,
    input  logic        io_clr_ac,
    input  logic [0:11] io_data,
    input  logic        dev_wait,
    output logic        busy,
    output logic [0:5]  dev_sel,
    output logic        iop1,
    output logic        iop2,
    output logic        iop4,
    output logic        done,
    output logic        skip,
    output logic        clr_ac,
    output logic [0:11] in_bus,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_P1, S_G1, S_P2, S_G2, S_P4, S_G4, S_DONE
    } state_t;

    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);
    localparam logic [11:0] WAIT_MAX = 12'(TIMEOUT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  mask_r;
    logic [3:0]  gap_cnt_r;
    logic [11:0] wait_cnt_r;

    logic       is_iot_s;
    logic       accept_s;
    logic       in_gap_s;
    logic       in_strobe_s;
    logic       last_gap_s;
    logic       timeout_hit_s;
    logic [2:0] start_mask_s;

    // Next enabled strobe phase after the given point; mask[0]=IOP1, mask[1]=IOP2, mask[2]=IOP4.
    function automatic state_t phase_after(input state_t cur, input logic [2:0] mask);
        state_t nxt;
        nxt = S_DONE;
        case (cur)
            S_IDLE: begin
                if (mask[0]) nxt = S_P1;
                else if (mask[1]) nxt = S_P2;
                else if (mask[2]) nxt = S_P4;
                else nxt = S_DONE;
            end
            S_G1: begin
                if (mask[1]) nxt = S_P2;
                else if (mask[2]) nxt = S_P4;
                else nxt = S_DONE;
            end
            S_G2: begin
                if (mask[2]) nxt = S_P4;
                else nxt = S_DONE;
            end
            default: nxt = S_DONE;
        endcase
        return nxt;
    endfunction

    // Request decode and gap status flags.
    always_comb begin
        is_iot_s      = (instruction[0:2] == 3'o6);
        start_mask_s  = {instruction[9], instruction[10], instruction[11]};
        accept_s      = (state_r == S_IDLE) && start;
        in_gap_s      = (state_r == S_G1) || (state_r == S_G2) || (state_r == S_G4);
        in_strobe_s   = (state_r == S_P1) || (state_r == S_P2) || (state_r == S_P4);
        last_gap_s    = in_gap_s && (gap_cnt_r == GAP_LAST);
        timeout_hit_s = last_gap_s && (wait_cnt_r == WAIT_MAX);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && is_iot_s) state_nxt_s = phase_after(S_IDLE, start_mask_s);
                else if (start) state_nxt_s = S_DONE;
                else state_nxt_s = S_IDLE;
            end
            S_P1: state_nxt_s = S_G1;
            S_P2: state_nxt_s = S_G2;
            S_P4: state_nxt_s = S_G4;
            S_G1, S_G2, S_G4: begin
                // Only the last gap cycle may be stretched; the wait limit overrides dev_wait.
                if (!last_gap_s) state_nxt_s = state_r;
                else if (timeout_hit_s) state_nxt_s = S_DONE;
                else if (dev_wait) state_nxt_s = state_r;
                else state_nxt_s = phase_after(state_r, mask_r);
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Gap and wait counters, cleared whenever the FSM is outside a gap state.
    always_ff @(posedge clk) begin
        if (reset || !in_gap_s) begin
            gap_cnt_r  <= 4'd0;
            wait_cnt_r <= 12'd0;
        end else if (!last_gap_s) begin
            gap_cnt_r <= gap_cnt_r + 4'd1;
        end else if (!timeout_hit_s && dev_wait) begin
            wait_cnt_r <= wait_cnt_r + 12'd1;
        end
    end

    // State register, registered strobes/status and result accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            mask_r  <= 3'b000;
            busy    <= 1'b0;
            dev_sel <= 6'o00;
            iop1    <= 1'b0;
            iop2    <= 1'b0;
            iop4    <= 1'b0;
            done    <= 1'b0;
            skip    <= 1'b0;
            clr_ac  <= 1'b0;
            in_bus  <= 12'o0000;
            timeout <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != S_IDLE);
            iop1    <= (state_nxt_s == S_P1);
            iop2    <= (state_nxt_s == S_P2);
            iop4    <= (state_nxt_s == S_P4);
            done    <= (state_nxt_s == S_DONE);
            if (accept_s) begin
                mask_r  <= is_iot_s ? start_mask_s : 3'b000;
                dev_sel <= is_iot_s ? instruction[3:8] : 6'o00;
                skip    <= 1'b0;
                clr_ac  <= 1'b0;
                in_bus  <= 12'o0000;
                timeout <= 1'b0;
            end else begin
                if (state_nxt_s == S_IDLE) dev_sel <= 6'o00;
                if (in_strobe_s) begin
                    skip   <= skip | io_skip;
                    clr_ac <= clr_ac | io_clr_ac;
                    in_bus <= in_bus | io_data;
                end
                if (timeout_hit_s) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iot_sequencer.sv
// Randomized bench for iot_sequencer: two instances (TIMEOUT 255 and 4) share stimulus and
// are checked cycle by cycle against a phase-level reference model.
module tb_iot_sequencer;
    localparam int GAP = 2;
    localparam int NC  = 64;

    logic        clk = 1'b0;
    logic        reset, start, io_skip, io_clr_ac, dev_wait;
    logic [0:11] instruction, io_data;
    logic [1:0]  busy_o, iop1_o, iop2_o, iop4_o, done_o, skip_o, clr_o, to_o;
    logic [0:5]  sel_o [2];
    logic [0:11] bus_o [2];

    int n_cmp = 0;
    int n_bad = 0;
    int to_lim [2] = '{255, 4};

    logic        v_skip [NC];
    logic        v_clr  [NC];
    logic        v_wait [NC];
    logic        v_start[NC];
    logic [0:11] v_data [NC];

    int          e_str [2][NC];
    int          e_done[2];
    logic        e_skip[2], e_clr[2], e_to[2];
    logic [0:11] e_bus [2];

    always #5 clk = ~clk;

    iot_sequencer dut0 (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .io_skip(io_skip), .io_clr_ac(io_clr_ac), .io_data(io_data), .dev_wait(dev_wait),
        .busy(busy_o[0]), .dev_sel(sel_o[0]), .iop1(iop1_o[0]), .iop2(iop2_o[0]),
        .iop4(iop4_o[0]), .done(done_o[0]), .skip(skip_o[0]), .clr_ac(clr_o[0]),
        .in_bus(bus_o[0]), .timeout(to_o[0])
    );

    iot_sequencer #(.GAP(GAP), .TIMEOUT(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .io_skip(io_skip), .io_clr_ac(io_clr_ac), .io_data(io_data), .dev_wait(dev_wait),
        .busy(busy_o[1]), .dev_sel(sel_o[1]), .iop1(iop1_o[1]), .iop2(iop2_o[1]),
        .iop4(iop4_o[1]), .done(done_o[1]), .skip(skip_o[1]), .clr_ac(clr_o[1]),
        .in_bus(bus_o[1]), .timeout(to_o[1])
    );

    task automatic clear_vec(input bit noise);
        for (int i = 0; i < NC; i++) begin
            v_skip[i]  = noise ? 1'($urandom % 2) : 1'b0;
            v_clr[i]   = noise ? 1'($urandom % 2) : 1'b0;
            v_data[i]  = noise ? 12'($urandom) : 12'o0000;
            v_wait[i]  = (noise && i < 40) ? ($urandom % 3 == 0) : 1'b0;
            v_start[i] = noise ? ($urandom % 4 == 0) : 1'b0;
        end
    endtask

    // Phase-level model: each enabled phase strobes at t, waits GAP cycles, then is stretched
    // by the run of dev_wait starting on its last gap cycle, capped by the timeout limit.
    task automatic model(input logic [0:11] ins);
        int t, k, iv;
        bit ab;
        iv = int'(ins);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NC; i++) e_str[d][i] = 0;
            e_skip[d] = 1'b0; e_clr[d] = 1'b0; e_to[d] = 1'b0; e_bus[d] = 12'o0000;
            t = 1; ab = 1'b0;
            if ((iv >> 9) == 6) begin
                for (int p = 1; p <= 4; p = p * 2) begin
                    if (!ab && (iv & p) != 0) begin
                        e_str[d][t] = p;
                        e_skip[d] = e_skip[d] | v_skip[t];
                        e_clr[d]  = e_clr[d] | v_clr[t];
                        e_bus[d]  = e_bus[d] | v_data[t];
                        k = 0;
                        while (t + GAP + k < NC && v_wait[t + GAP + k] && k < to_lim[d]) k++;
                        if (k >= to_lim[d]) begin
                            t = t + GAP + to_lim[d] + 1;
                            e_to[d] = 1'b1;
                            ab = 1'b1;
                        end else begin
                            t = t + GAP + k + 1;
                        end
                    end
                end
            end
            e_done[d] = t;
        end
    endtask

    // Start one instruction at cycle T and compare every cycle through done+2 on both DUTs.
    task automatic run_sequence(input string name, input logic [0:11] ins);
        int kmax, kmin, sel;
        logic [10:0] got, exp;
        logic [14:0] rgot, rexp;
        model(ins);
        sel  = ((int'(ins) >> 9) == 6) ? ((int'(ins) >> 3) & 63) : 0;
        kmax = (e_done[0] > e_done[1] ? e_done[0] : e_done[1]) + 2;
        kmin = (e_done[0] < e_done[1] ? e_done[0] : e_done[1]);
        @(posedge clk); #1;
        instruction = ins; start = 1'b1;
        io_skip = 1'b0; io_clr_ac = 1'b0; io_data = 12'o0000; dev_wait = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                exp = {k <= e_done[d], e_str[d][k] == 1, e_str[d][k] == 2, e_str[d][k] == 4,
                       k == e_done[d], (k <= e_done[d]) ? 6'(sel) : 6'o00};
                got = {busy_o[d], iop1_o[d], iop2_o[d], iop4_o[d], done_o[d], sel_o[d]};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL %s ctl dut%0d k=%0d: got %b expected %b", name, d, k, got, exp);
                end
                if (k >= e_done[d]) begin
                    rexp = {e_skip[d], e_clr[d], e_to[d], e_bus[d]};
                    rgot = {skip_o[d], clr_o[d], to_o[d], bus_o[d]};
                    n_cmp++;
                    if (rgot !== rexp) begin
                        n_bad++;
                        $display("FAIL %s results dut%0d k=%0d: got %b expected %b", name, d, k, rgot, rexp);
                    end
                end
            end
            start       = (k <= kmin) ? v_start[k] : 1'b0;
            instruction = 12'($urandom);
            io_skip     = v_skip[k];
            io_clr_ac   = v_clr[k];
            io_data     = v_data[k];
            dev_wait    = v_wait[k];
        end
        start = 1'b0; dev_wait = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({busy_o[d], iop1_o[d], iop2_o[d], iop4_o[d], done_o[d], skip_o[d], clr_o[d], to_o[d],
                 sel_o[d], bus_o[d]} !== 26'd0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got busy=%b sel=%o bus=%o expected all zero",
                         d, busy_o[d], sel_o[d], bus_o[d]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_6467();
        clear_vec(1'b0);
        run_sequence("iot6467", 12'o6467);
    endtask

    task automatic test_6034();
        clear_vec(1'b0);
        v_data[1] = 12'o0215;
        v_clr[1]  = 1'b1;
        run_sequence("iot6034", 12'o6034);
        n_cmp++;
        if (bus_o[0] !== 12'o0215 || clr_o[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL iot6034_hold: got in_bus=%o clr_ac=%b expected 0215 1", bus_o[0], clr_o[0]);
        end
    endtask

    task automatic test_skip();
        clear_vec(1'b0);
        v_skip[1] = 1'b1;
        run_sequence("skip_strobe", 12'o6031);
        n_cmp++;
        if (skip_o[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL skip_strobe_hold: got %b expected 1", skip_o[0]);
        end
        clear_vec(1'b0);
        v_skip[2] = 1'b1;
        v_skip[3] = 1'b1;
        run_sequence("skip_gap", 12'o6031);
        n_cmp++;
        if (skip_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL skip_gap_hold: got %b expected 0", skip_o[0]);
        end
    endtask

    task automatic test_wait();
        clear_vec(1'b0);
        for (int i = 3; i <= 7; i++) v_wait[i] = 1'b1;
        run_sequence("wait5", 12'o6031);
        clear_vec(1'b0);
        for (int i = 3; i <= 25; i++) v_wait[i] = 1'b1;
        run_sequence("wait_held", 12'o6031);
        n_cmp++;
        if (to_o !== 2'b10) begin
            n_bad++;
            $display("FAIL wait_held_timeout: got %b expected 10", to_o);
        end
    endtask

    task automatic test_non_iot();
        clear_vec(1'b1);
        for (int i = 0; i < NC; i++) v_start[i] = 1'b0;
        run_sequence("non_iot7200", 12'o7200);
        run_sequence("iot_no_phase", 12'o6030);
    endtask

    task automatic test_back_to_back();
        clear_vec(1'b0);
        v_start[5]  = 1'b1;
        v_start[10] = 1'b1;
        run_sequence("busy_start", 12'o6357);
    endtask

    task automatic test_random();
        logic [0:11] ins;
        for (int n = 0; n < 30; n++) begin
            clear_vec(1'b1);
            ins = ($urandom % 4 != 0) ? {3'o6, 9'($urandom)} : 12'($urandom);
            run_sequence("random", ins);
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        instruction = 12'o6557; start = 1'b1;
        io_skip = 1'b1; io_clr_ac = 1'b1; io_data = 12'o7777; dev_wait = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                n_cmp++;
                if (iop1_o !== 2'b11) begin
                    n_bad++;
                    $display("FAIL mid_reset_iop1: got %b expected 11", iop1_o);
                end
            end
            if (k >= 4) begin
                for (int d = 0; d < 2; d++) begin
                    n_cmp++;
                    if ({busy_o[d], iop1_o[d], iop2_o[d], iop4_o[d], done_o[d], skip_o[d], clr_o[d],
                         to_o[d], sel_o[d], bus_o[d]} !== 26'd0) begin
                        n_bad++;
                        $display("FAIL mid_reset dut%0d k=%0d: got busy=%b iop2=%b iop4=%b done=%b sel=%o expected all zero",
                                 d, k, busy_o[d], iop2_o[d], iop4_o[d], done_o[d], sel_o[d]);
                    end
                end
            end
            start = 1'b0;
            reset = (k == 3);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instruction = 12'o0000;
        io_skip = 1'b0; io_clr_ac = 1'b0; io_data = 12'o0000; dev_wait = 1'b0;
        test_reset();
        test_6467();
        test_6034();
        test_skip();
        test_wait();
        test_non_iot();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
